bypass_scoreboard: RTL

Parametrised operand bypass and hazard unit for the decode stage. Each of R read ports gets the youngest in-flight value for its physical register from S prioritised pipeline sources, or the register-file value. A registered per-register pending scoreboard tracks writers whose result cannot yet be forwarded (loads, multi-cycle ALU ops). When a read cannot be satisfied it raises `stall`, so decode no longer needs an external load-use check.

---
 rtl/bypass_pkg.sv | 25 ++
 rtl/bypass_port_mux.sv | 83 ++++++++
 rtl/bypass_scoreboard.sv | 107 ++++++++++
 3 files changed

// File: rtl/bypass_pkg.sv
// -----------------------------------------------------------------------------
// bypass_pkg
// Shared constants and helpers for the decode-stage bypass/hazard unit.
//   SRC_YOUNGEST : index of the youngest bypass source. Sources are ordered
//                  youngest-first, so the lowest matching index wins.
//   PREG_ZERO    : physical register that always reads as zero.
//   preg_count   : number of scoreboard entries for a given address width.
//   slice_lo     : low bit of element idx in a flattened vector of width-bit
//                  elements (element i lives at [i*W +: W]).
// -----------------------------------------------------------------------------
package bypass_pkg;

   localparam int unsigned SRC_YOUNGEST = 0;
   localparam int unsigned PREG_ZERO    = 0;

   function automatic int unsigned preg_count(input int unsigned addr_width);
      return 1 << addr_width;
   endfunction

   function automatic int unsigned slice_lo(input int unsigned idx,
                                            input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/bypass_port_mux.sv
// -----------------------------------------------------------------------------
// bypass_port_mux
// Operand selection and hazard detection for one decode read port.
// Resolution order for an enabled port with a non-zero address:
//   1. youngest matching bypass source (ready -> its data, else hazard)
//   2. same-cycle register-file commit
//   3. pending scoreboard bit -> hazard
//   4. register-file read value
// Ports:
//   en           in   port uses an operand
//   addr         in   physical source register
//   rf_data      in   register-file read value
//   src_wb       in   per-source write enable (NUM_SRCS)
//   src_ready    in   per-source value is final (NUM_SRCS)
//   src_addr     in   flattened per-source destination
//   src_data     in   flattened per-source value
//   commit_valid in   register-file write this cycle
//   commit_addr  in   register being written
//   commit_data  in   value being written
//   pending      in   registered scoreboard, one bit per register
//   override     out  operand for this port (rf_data while hazard is raised)
//   hazard       out  operand cannot be supplied this cycle
// -----------------------------------------------------------------------------
module bypass_port_mux
   import bypass_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned PREG_ADDR_WIDTH = 6,
   parameter int unsigned NUM_SRCS        = 3
) (
   input  logic                                    en,
   input  logic [PREG_ADDR_WIDTH-1:0]              addr,
   input  logic [DATA_WIDTH-1:0]                   rf_data,
   input  logic [NUM_SRCS-1:0]                     src_wb,
   input  logic [NUM_SRCS-1:0]                     src_ready,
   input  logic [NUM_SRCS*PREG_ADDR_WIDTH-1:0]     src_addr,
   input  logic [NUM_SRCS*DATA_WIDTH-1:0]          src_data,
   input  logic                                    commit_valid,
   input  logic [PREG_ADDR_WIDTH-1:0]              commit_addr,
   input  logic [DATA_WIDTH-1:0]                   commit_data,
   input  logic [preg_count(PREG_ADDR_WIDTH)-1:0]  pending,
   output logic [DATA_WIDTH-1:0]                   override,
   output logic                                    hazard
);

   logic                  hit;
   logic                  hit_ready;
   logic [DATA_WIDTH-1:0] hit_data;

   // Walk from oldest to youngest so the youngest match overwrites the rest.
   always_comb begin
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_data  = '0;
      for (int s = NUM_SRCS - 1; s >= int'(SRC_YOUNGEST); s--) begin
         if (src_wb[s] &&
             src_addr[slice_lo(s, PREG_ADDR_WIDTH) +: PREG_ADDR_WIDTH] == addr) begin
            hit       = 1'b1;
            hit_ready = src_ready[s];
            hit_data  = src_data[slice_lo(s, DATA_WIDTH) +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      override = rf_data;
      hazard   = 1'b0;
      if (en) begin
         if (addr == PREG_ADDR_WIDTH'(PREG_ZERO)) begin
            override = '0;
         end else if (hit) begin
            // A not-yet-ready youngest writer blocks older sources and the RF.
            if (hit_ready) override = hit_data;
            else           hazard   = 1'b1;
         end else if (commit_valid && commit_addr == addr) begin
            override = commit_data;
         end else if (pending[addr]) begin
            hazard = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bypass_scoreboard.sv
// -----------------------------------------------------------------------------
// bypass_scoreboard
// Decode-stage operand bypass and hazard unit. Each read port gets the youngest
// in-flight value for its register; a registered pending bit per register
// tracks writers that cannot yet be forwarded. Any unsatisfiable read raises
// stall.
// Optional feature macro: BYPASS_PERF_EN adds a saturating stall-cycle counter
// with ports perf_clear (in) and perf_stall_cycles (out, 32 bits).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_en/addr/data     per read port enable, register, RF value (flattened)
//   src_wb/ready/addr/data  per bypass source, index 0 youngest (flattened)
//   issue_valid/wb/addr instruction leaving decode and its destination
//   commit_valid/addr/data  register-file write
//   flush               kill all in-flight writers
//   rd_override         operand per port
//   stall               decode must hold
// -----------------------------------------------------------------------------
module bypass_scoreboard
   import bypass_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned PREG_ADDR_WIDTH = 6,
   parameter int unsigned READ_PORTS      = 2,
   parameter int unsigned NUM_SRCS        = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [READ_PORTS-1:0]                 rd_en,
   input  logic [READ_PORTS*PREG_ADDR_WIDTH-1:0] rd_addr,
   input  logic [READ_PORTS*DATA_WIDTH-1:0]      rd_data,
   input  logic [NUM_SRCS-1:0]                   src_wb,
   input  logic [NUM_SRCS-1:0]                   src_ready,
   input  logic [NUM_SRCS*PREG_ADDR_WIDTH-1:0]   src_addr,
   input  logic [NUM_SRCS*DATA_WIDTH-1:0]        src_data,
   input  logic                                  issue_valid,
   input  logic                                  issue_wb,
   input  logic [PREG_ADDR_WIDTH-1:0]            issue_addr,
   input  logic                                  commit_valid,
   input  logic [PREG_ADDR_WIDTH-1:0]            commit_addr,
   input  logic [DATA_WIDTH-1:0]                 commit_data,
   input  logic                                  flush,
   output logic [READ_PORTS*DATA_WIDTH-1:0]      rd_override,
`ifdef BYPASS_PERF_EN
   input  logic                                  perf_clear,
   output logic [31:0]                           perf_stall_cycles,
`endif
   output logic                                  stall
);

   localparam int unsigned NUM_PREGS = preg_count(PREG_ADDR_WIDTH);
   localparam logic [PREG_ADDR_WIDTH-1:0] ZERO_ADDR = PREG_ADDR_WIDTH'(PREG_ZERO);

   logic [NUM_PREGS-1:0]  pending;
   logic [READ_PORTS-1:0] port_hazard;
   logic                  issue_set;
   logic                  commit_clear;

   for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
      bypass_port_mux #(
         .DATA_WIDTH      (DATA_WIDTH),
         .PREG_ADDR_WIDTH (PREG_ADDR_WIDTH),
         .NUM_SRCS        (NUM_SRCS)
      ) u_mux (
         .en           (rd_en[i]),
         .addr         (rd_addr[slice_lo(i, PREG_ADDR_WIDTH) +: PREG_ADDR_WIDTH]),
         .rf_data      (rd_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
         .src_wb       (src_wb),
         .src_ready    (src_ready),
         .src_addr     (src_addr),
         .src_data     (src_data),
         .commit_valid (commit_valid),
         .commit_addr  (commit_addr),
         .commit_data  (commit_data),
         .pending      (pending),
         .override     (rd_override[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
         .hazard       (port_hazard[i])
      );
   end

   assign stall = |port_hazard;

   // A stalled decode has not really issued, so it must not mark its target.
   assign issue_set    = issue_valid && issue_wb && !stall && (issue_addr != ZERO_ADDR);
   assign commit_clear = commit_valid && (commit_addr != ZERO_ADDR);

   // Set is written after clear so a same-address set/clear leaves the bit set.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pending <= '0;
      end else begin
         if (commit_clear) pending[commit_addr] <= 1'b0;
         if (issue_set)    pending[issue_addr]  <= 1'b1;
      end
   end

`ifdef BYPASS_PERF_EN
   always_ff @(posedge clk) begin
      if (rst || perf_clear) begin
         perf_stall_cycles <= '0;
      end else if (stall && perf_stall_cycles != 32'hFFFF_FFFF) begin
         perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule
